// File: rtl/reg_dump_if.sv
`default_nettype none
// ============================================================================
// reg_dump_if : control, register-file read port and word stream of reg_dump
// Revision 1.0
// ============================================================================
interface reg_dump_if;
  logic        start;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;

  modport master (
    input  start, abort, rd_data, dump_ready,
    output rd_addr, dump_valid, dump_index, dump_data, busy, done
  );

  modport slave (
    output start, abort, rd_data, dump_ready,
    input  rd_addr, dump_valid, dump_index, dump_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// reg_dump : streams register-file words FIRST_REG..LAST_REG out over a
//            valid/ready channel, one read per word.
// Revision 1.0
// ============================================================================
module reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  reg_dump_if.master   bus
);

  generate
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
      $fatal(1, "reg_dump: register range must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] C_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] C_LAST  = 5'(LAST_REG);

  logic [1:0]  state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [4:0]  dump_index_q, dump_index_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic        xfer;

  assign xfer = (state_q == S_SEND) && bus.dump_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over every transition except in IDLE, where start wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_ADDR;
      S_ADDR: state_d = bus.abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          state_d = (index_q == C_LAST) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    index_d      = index_q;
    dump_index_d = dump_index_q;
    dump_data_d  = dump_data_q;
    if (state_q == S_IDLE && bus.start) begin
      index_d = C_FIRST;
    end
    if (state_q == S_ADDR && !bus.abort) begin
      dump_data_d  = bus.rd_data;
      dump_index_d = index_q;
    end
    // Stopping at LAST_REG keeps the index from wrapping past 31.
    if (xfer && !bus.abort && index_q != C_LAST) begin
      index_d = index_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q      <= 5'd0;
      dump_index_q <= 5'd0;
      dump_data_q  <= 32'd0;
    end else begin
      index_q      <= index_d;
      dump_index_q <= dump_index_d;
      dump_data_q  <= dump_data_d;
    end
  end

  always_comb begin
    bus.rd_addr    = (state_q == S_ADDR) ? index_q : 5'd0;
    bus.dump_valid = (state_q == S_SEND);
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.dump_index = dump_index_q;
    bus.dump_data  = dump_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
// tb_reg_dump : directed checks of reg_dump over three register ranges
// Revision 1.0
// ============================================================================
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] regs [32];

  logic        start_r [3];
  logic        abort_r [3];
  logic        ready_r [3];
  logic        valid_w [3];
  logic        done_w  [3];
  logic        busy_w  [3];
  logic [4:0]  addr_w  [3];
  logic [4:0]  idx_w   [3];
  logic [31:0] data_w  [3];

  reg_dump_if b0 ();
  reg_dump_if b1 ();
  reg_dump_if b2 ();

  reg_dump #(.FIRST_REG(0), .LAST_REG(31)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  reg_dump #(.FIRST_REG(1), .LAST_REG(2))  u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  reg_dump #(.FIRST_REG(2), .LAST_REG(2))  u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  assign b0.start = start_r[0]; assign b0.abort = abort_r[0]; assign b0.dump_ready = ready_r[0];
  assign b1.start = start_r[1]; assign b1.abort = abort_r[1]; assign b1.dump_ready = ready_r[1];
  assign b2.start = start_r[2]; assign b2.abort = abort_r[2]; assign b2.dump_ready = ready_r[2];
  assign b0.rd_data = regs[b0.rd_addr];
  assign b1.rd_data = regs[b1.rd_addr];
  assign b2.rd_data = regs[b2.rd_addr];

  assign valid_w[0] = b0.dump_valid; assign done_w[0] = b0.done; assign busy_w[0] = b0.busy;
  assign valid_w[1] = b1.dump_valid; assign done_w[1] = b1.done; assign busy_w[1] = b1.busy;
  assign valid_w[2] = b2.dump_valid; assign done_w[2] = b2.done; assign busy_w[2] = b2.busy;
  assign addr_w[0] = b0.rd_addr; assign idx_w[0] = b0.dump_index; assign data_w[0] = b0.dump_data;
  assign addr_w[1] = b1.rd_addr; assign idx_w[1] = b1.dump_index; assign data_w[1] = b1.dump_data;
  assign addr_w[2] = b2.rd_addr; assign idx_w[2] = b2.dump_index; assign data_w[2] = b2.dump_data;

  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  int          done_edge;
  int          first_valid;
  int          stalls;
  logic [4:0]  q_idx [$];
  logic [31:0] q_dat [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    if (i == 1) return 32'hFFFF_FFFF;
    if (i == 2) return 32'hAAAA_AAAA;
    return 32'h0;
  endfunction

  // Pulse start on instance s and collect accepted words until done or the cycle budget runs out.
  task automatic run_dump(input int s, input int stall_idx, input bit repulse);
    bit fin;
    q_idx.delete(); q_dat.delete();
    done_edge = -1; first_valid = -1; stalls = 0; fin = 0;
    start_r[s] = 1'b1; ready_r[s] = 1'b1;
    tick();
    start_r[s] = 1'b0;
    for (int e = 1; e <= 90 && !fin; e++) begin
      tick();
      if (repulse) start_r[s] = (e == 10 || e == 11);
      if (valid_w[s]) begin
        if (int'(idx_w[s]) == stall_idx && stalls < 5) begin
          chk("bp_data", data_w[s], 32'hAAAA_AAAA);
          chk("bp_index", 32'(idx_w[s]), 32'd2);
          stalls++;
          ready_r[s] = 1'b0;
        end else begin
          ready_r[s] = 1'b1;
          q_idx.push_back(idx_w[s]);
          q_dat.push_back(data_w[s]);
          if (first_valid < 0) first_valid = e;
        end
      end
      if (done_w[s]) begin
        done_edge = e;
        fin = 1;
      end
    end
    start_r[s] = 1'b0;
  endtask

  task automatic check_words(input int first, input int last);
    chk("word_count", 32'(q_idx.size()), 32'(last - first + 1));
    for (int i = 0; i < q_idx.size(); i++) begin
      chk($sformatf("word%0d_index", i), 32'(q_idx[i]), 32'(first + i));
      chk($sformatf("word%0d_data", i), q_dat[i], exp_data(first + i));
    end
  endtask

  initial begin
    bit found;
    bit any;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'hAAAA_AAAA;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; abort_r[i] = 1'b0; ready_r[i] = 1'b1;
    end

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_valid", 32'(valid_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_rd_addr", 32'(addr_w[0]), 32'd0);
    chk("rst_index", 32'(idx_w[0]), 32'd0);
    chk("rst_data", data_w[0], 32'd0);
    rst = 1'b0;

    // Full dump with a start re-pulse while busy
    run_dump(0, -1, 1'b1);
    chk("full_first_valid_edge", 32'(first_valid), 32'd1);
    chk("full_done_edge", 32'(done_edge), 32'd64);
    check_words(0, 31);
    tick();
    chk("full_done_width", 32'(done_w[0]), 32'd0);
    chk("full_busy_after", 32'(busy_w[0]), 32'd0);
    chk("full_rd_addr_idle", 32'(addr_w[0]), 32'd0);

    // Backpressure on index 2
    run_dump(0, 2, 1'b0);
    chk("bp_stall_cycles", 32'(stalls), 32'd5);
    chk("bp_done_edge", 32'(done_edge), 32'd69);
    check_words(0, 31);
    tick();

    // Abort in IDLE does nothing
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;
    chk("idle_abort_busy", 32'(busy_w[0]), 32'd0);

    // Abort during SEND of index 1 with dump_ready low
    start_r[0] = 1'b1; ready_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    found = 0;
    for (int e = 1; e <= 10 && !found; e++) begin
      tick();
      if (valid_w[0] && idx_w[0] == 5'd1) found = 1;
    end
    chk("abort_reach_index1", 32'(found), 32'd1);
    ready_r[0] = 1'b0;
    chk("abort_data1", data_w[0], 32'hFFFF_FFFF);
    tick();
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;
    chk("abort_valid", 32'(valid_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    any = 0;
    repeat (3) begin
      tick();
      if (done_w[0] || busy_w[0]) any = 1;
    end
    chk("abort_quiet", 32'(any), 32'd0);

    // Start and abort together in IDLE: start wins, dump restarts at index 0
    start_r[0] = 1'b1; abort_r[0] = 1'b1; ready_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0; abort_r[0] = 1'b0;
    chk("startwin_busy", 32'(busy_w[0]), 32'd1);
    tick();
    chk("startwin_valid", 32'(valid_w[0]), 32'd1);
    chk("startwin_index", 32'(idx_w[0]), 32'd0);
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;

    // Asynchronous reset during ADDR of index 5
    start_r[0] = 1'b1; ready_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      tick();
      if (busy_w[0] && !valid_w[0] && addr_w[0] == 5'd5) found = 1;
    end
    chk("rstmid_reach_addr5", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy_w[0]), 32'd0);
    chk("rstmid_valid", 32'(valid_w[0]), 32'd0);
    chk("rstmid_done", 32'(done_w[0]), 32'd0);
    chk("rstmid_rd_addr", 32'(addr_w[0]), 32'd0);
    chk("rstmid_index", 32'(idx_w[0]), 32'd0);
    chk("rstmid_data", data_w[0], 32'd0);
    repeat (2) tick();
    #2 rst = 1'b0;
    any = 0;
    repeat (70) begin
      tick();
      if (valid_w[0] || done_w[0] || busy_w[0]) any = 1;
    end
    chk("rstmid_no_activity", 32'(any), 32'd0);

    // Start accepted at the first edge after reset release
    rst = 1'b1;
    tick();
    #2 rst = 1'b0;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    chk("postrst_busy", 32'(busy_w[0]), 32'd1);
    tick();
    chk("postrst_valid", 32'(valid_w[0]), 32'd1);
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;

    // Range 1..2
    run_dump(1, -1, 1'b0);
    chk("r12_first_valid_edge", 32'(first_valid), 32'd1);
    chk("r12_done_edge", 32'(done_edge), 32'd4);
    check_words(1, 2);
    tick();
    chk("r12_busy_after", 32'(busy_w[1]), 32'd0);

    // Single register 2..2
    run_dump(2, -1, 1'b0);
    chk("r22_done_edge", 32'(done_edge), 32'd2);
    check_words(2, 2);
    tick();
    chk("r22_busy_after", 32'(busy_w[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter FIRST_REG, default 0, lowest register index dumped.
REQ-002 Parameter LAST_REG, default 31, highest register index dumped; FIRST_REG <= LAST_REG <= 31 SHALL be checked at elaboration, and a violation SHALL be a fatal error.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request a dump; sampled only in IDLE.
REQ-006 abort  in  1  synchronous cancel of a dump in progress.
REQ-007 rd_addr  out  5  register-file read address, to the register file's read port.
REQ-008 rd_data  in  32  register-file read data; combinational response to rd_addr.
REQ-009 dump_valid  out  1  dump_index/dump_data hold a word.
REQ-010 dump_ready  in  1  consumer accepts the word.
REQ-011 dump_index  out  5  register index of the current word.
REQ-012 dump_data  out  32  captured register contents.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ADDR, SEND and DONE.
REQ-016 IDLE: with start=1 at an edge, the index SHALL load FIRST_REG and the FSM SHALL go to ADDR.
REQ-017 ADDR: rd_addr SHALL equal the index, and at the next edge rd_data SHALL be registered into dump_data, the index into dump_index, and the FSM SHALL go to SEND.
REQ-018 SEND: dump_valid SHALL be 1.
REQ-019 In SEND, dump_data and dump_index SHALL be held stable while dump_ready=0.
REQ-020 In SEND, dump_valid&dump_ready at an edge SHALL be a transfer: if index==LAST_REG go to DONE, else increment the index and go to ADDR.
REQ-021 DONE: done SHALL be 1 for exactly one cycle, followed by IDLE.
REQ-022 Latency: start accepted at edge N -> dump_valid high from cycle N+2.
REQ-023 Throughput: with dump_ready=1, one word every 2 cycles.
REQ-024 A full default dump SHALL raise done in cycle N+65.
REQ-025 rd_addr SHALL be 0 in every state except ADDR.
REQ-026 dump_valid SHALL be 0 in every state except SEND.
REQ-027 start outside IDLE SHALL be ignored, with no restart or queuing.
REQ-028 start in DONE SHALL be ignored.
REQ-029 abort=1 at an edge in ADDR, SEND or DONE SHALL return the FSM to IDLE with no done pulse.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 abort in the same edge as a SEND transfer: the transfer SHALL count as completed, then the FSM SHALL go to IDLE with no done pulse.
REQ-032 abort and start both high in IDLE: start SHALL win.
REQ-033 FIRST_REG==LAST_REG SHALL dump exactly one word, then DONE.
REQ-034 The index SHALL never wrap: LAST_REG=31 terminates without incrementing to 0.
REQ-035 Index x0 SHALL be read like any other register; no special-casing.

Reset
REQ-036 RST=1 SHALL force IDLE immediately, independent of CLK.
REQ-037 RST=1 SHALL force busy=0, done=0, dump_valid=0, rd_addr=0, dump_index=0, dump_data=0 and index=0.
REQ-038 Reset asserted mid-dump SHALL discard the dump with no done pulse.
REQ-039 After RST deasserts, the block SHALL accept start at the first rising edge.

Verification
REQ-040 Full dump: register file preloaded x1=FFFFFFFF, x2=AAAAAAAA, others 0, dump_ready=1, pulse start -> 32 words, indices 0..31 in order, data 0, FFFFFFFF, AAAAAAAA, then 0 ... 0; done in cycle N+65; busy low afterwards.
REQ-041 Backpressure: dump_ready=0 for 5 cycles while index 2 is presented -> dump_valid stays 1 and dump_data=AAAAAAAA/dump_index=2 stay stable for all 5 cycles; dump resumes on dump_ready=1 with no duplicated or lost word.
REQ-042 Abort: abort asserted during SEND of index 1 with dump_ready=0 -> IDLE next cycle, dump_valid=0, busy=0, no done; a following start dumps again from index 0.
REQ-043 Reset mid-dump: RST pulsed between clock edges during ADDR of index 5 -> all outputs 0 immediately; no further words; done never asserts.
REQ-044 Ignored start and ranges: start re-pulsed while busy -> word sequence unchanged; FIRST_REG=1, LAST_REG=2 -> exactly FFFFFFFF then AAAAAAAA, then done; FIRST_REG=LAST_REG=2 -> single word AAAAAAAA then done.
